// File: rtl/lsu.sv
// lsu: RV32I byte/half/word load/store unit on a req/gnt/rvalid data bus.
// Ports: ex_* request in, lsu_busy/lsu_done/load_data/misalign_err to the
// pipeline, mem_* bus side. Optional macro: LSU_MISALIGN_CHECK_EN.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [31:0]       rs2_data,
  output logic              lsu_busy,
  output logic              lsu_done,
  output logic [31:0]       load_data,
  output logic              misalign_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       ld_q;

  logic        start;
  logic        byte_acc;
  logic        half_acc;
  logic        misal;
  logic [31:0] wdata_fmt;
  logic [3:0]  be_fmt;
  logic [31:0] ld_ext;
  logic [31:0] rd_shift;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  assign start = ex_valid & (ex_load | ex_store);

  // Loads decode size from funct3[1:0] (LBU/LHU share it);
  // stores only treat 000/001 as sub-word.
  assign byte_acc = ex_load ? (funct3[1:0] == 2'b00)
                            : (funct3 == 3'b000);
  assign half_acc = ex_load ? (funct3[1:0] == 2'b01)
                            : (funct3 == 3'b001);

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;

  always_comb begin
    misal = 1'b0;
    unique case (1'b1)
      byte_acc: misal = 1'b0;
      half_acc: misal = alu_res[0];
      default:  misal = |alu_res[1:0];
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    wdata_fmt = rs2_data;
    be_fmt    = 4'b1111;
    unique case (1'b1)
      byte_acc: begin
        wdata_fmt = {4{rs2_data[7:0]}};
        be_fmt    = 4'b0001 << alu_res[1:0];
      end
      half_acc: begin
        wdata_fmt = {2{rs2_data[15:0]}};
        be_fmt    = alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign rd_shift = mem_rdata >> {off_q, 3'b000};
  assign rd_b     = rd_shift[7:0];
  assign rd_h     = off_q[1] ? mem_rdata[31:16]
                             : mem_rdata[15:0];

  always_comb begin
    ld_ext = mem_rdata;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00):
        ld_ext = {{24{~f3_q[2] & rd_b[7]}}, rd_b};
      (f3_q[1:0] == 2'b01):
        ld_ext = {{16{~f3_q[2] & rd_h[15]}}, rd_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = misal ? DONE : REQ;
      end
      REQ: begin
        if (mem_gnt) state_d = we_q ? DONE : WAIT_R;
      end
      WAIT_R: begin
        if (mem_rvalid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
    end else if (state_q == IDLE && start) begin
      addr_q  <= {alu_res[ADDR_W-1:2], 2'b00};
      off_q   <= alu_res[1:0];
      f3_q    <= funct3;
      we_q    <= ~ex_load;
      wdata_q <= wdata_fmt;
      be_q    <= be_fmt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q <= '0;
    end else if (state_q == WAIT_R && mem_rvalid) begin
      ld_q <= ld_ext;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      err_q <= start & misal;
    end
  end
`endif

  always_comb begin
    mem_req      = (state_q == REQ);
    lsu_done     = (state_q == DONE);
    lsu_busy     = (state_q == REQ) | (state_q == WAIT_R) |
                   ((state_q == IDLE) & start);
`ifdef LSU_MISALIGN_CHECK_EN
    misalign_err = (state_q == DONE) & err_q;
`else
    misalign_err = 1'b0;
`endif
    mem_we       = we_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    mem_be       = be_q;
    load_data    = ld_q;
  end

endmodule
